// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit.
// Next-PC select codes and return-stack pointer sizing.
package pc_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_RET
    } pc_sel_e;

    localparam int RAS_DEPTH_DEF = 4;
    localparam int RAS_PTR_W     = $clog2(RAS_DEPTH_DEF);

    function automatic int ras_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between decode/control and the PC unit.
// master = control side, slave = pc_unit.
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             EN;
    logic             BR_TAKEN;
    logic [WIDTH-1:0] BR_OFFSET;
    logic             JMP;
    logic [WIDTH-1:0] JMP_TARGET;
    logic             CALL;
    logic             RET;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] PC_NEXT_SEQ;
    logic             RAS_EMPTY;
    logic             RAS_FULL;
    logic             RAS_ERR;

    modport master (
        output EN, BR_TAKEN, BR_OFFSET, JMP, JMP_TARGET, CALL, RET,
        input  PC, PC_NEXT_SEQ, RAS_EMPTY, RAS_FULL, RAS_ERR
    );

    modport slave (
        input  EN, BR_TAKEN, BR_OFFSET, JMP, JMP_TARGET, CALL, RET,
        output PC, PC_NEXT_SEQ, RAS_EMPTY, RAS_FULL, RAS_ERR
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: overflow overwrites the oldest entry,
// underflow leaves state unchanged; both set a sticky error flag.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = RAS_DEPTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full,
    output logic             err
);
    localparam int PW = ras_ptr_w(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_top;
    logic [PW:0]      r_cnt;
    logic             r_err;

    logic [PW-1:0]    w_top_nx;
    logic [PW:0]      w_cnt_nx;
    logic             w_err_nx;
    logic             w_wr;
    logic [PW-1:0]    w_wr_idx;
    logic             w_empty;
    logic             w_full;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == FULL_CNT);

    always_comb begin
        w_top_nx = r_top;
        w_cnt_nx = r_cnt;
        w_err_nx = r_err;
        w_wr     = 1'b0;
        w_wr_idx = r_top + PW'(1);
        case ({push, pop})
            2'b10: begin
                w_wr     = 1'b1;
                w_top_nx = r_top + PW'(1);
                if (w_full) w_err_nx = 1'b1;
                else        w_cnt_nx = r_cnt + 1'b1;
            end
            2'b01: begin
                if (w_empty) begin
                    w_err_nx = 1'b1;
                end else begin
                    w_top_nx = r_top - PW'(1);
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            2'b11: begin
                w_wr = 1'b1;
                if (w_empty) begin
                    w_top_nx = r_top + PW'(1);
                    w_cnt_nx = r_cnt + 1'b1;
                    w_err_nx = 1'b1;
                end else begin
                    // Pop and push cancel: overwrite top in place
                    w_wr_idx = r_top;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_top <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_top <= w_top_nx;
            r_cnt <= w_cnt_nx;
            r_err <= w_err_nx;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr) r_mem[w_wr_idx] <= push_data;
    end

    assign top_data = r_mem[r_top];
    assign empty    = w_empty;
    assign full     = w_full;
    assign err      = r_err;
endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC select, adders, PC register
// and return-address stack.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               STEP      = 1,
    parameter int               RAS_DEPTH = RAS_DEPTH_DEF
) (
    input logic     CLK,
    input logic     RST,
    pc_unit_if.slave bus
);
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_br;
    logic [WIDTH-1:0] w_pc_nx;
    logic [WIDTH-1:0] w_top;
    logic             w_empty;
    logic             w_full;
    logic             w_err;
    pc_sel_e          w_sel;

    assign w_seq = r_pc + WIDTH'(STEP);
    assign w_br  = w_seq + bus.BR_OFFSET;

    // RET on an empty stack falls through to sequential
    always_comb begin
        w_sel = SEL_SEQ;
        if (bus.RET)           w_sel = w_empty ? SEL_SEQ : SEL_RET;
        else if (bus.JMP)      w_sel = SEL_JMP;
        else if (bus.BR_TAKEN) w_sel = SEL_BR;
    end

    always_comb begin
        w_pc_nx = w_seq;
        unique case (w_sel)
            SEL_RET: w_pc_nx = w_top;
            SEL_JMP: w_pc_nx = bus.JMP_TARGET;
            SEL_BR:  w_pc_nx = w_br;
            SEL_SEQ: w_pc_nx = w_seq;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST)         r_pc <= RESET_VEC;
        else if (bus.EN) r_pc <= w_pc_nx;
    end

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK       (CLK),
        .RST       (RST),
        .push      (bus.EN & bus.CALL),
        .pop       (bus.EN & bus.RET),
        .push_data (w_seq),
        .top_data  (w_top),
        .empty     (w_empty),
        .full      (w_full),
        .err       (w_err)
    );

    assign bus.PC          = r_pc;
    assign bus.PC_NEXT_SEQ = w_seq;
    assign bus.RAS_EMPTY   = w_empty;
    assign bus.RAS_FULL    = w_full;
    assign bus.RAS_ERR     = w_err;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random control
// traffic against a queue-based reference model.
module tb_pc_unit;
    logic CLK;
    logic RST;

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(
        .WIDTH     (32),
        .RESET_VEC (32'h0),
        .STEP      (1),
        .RAS_DEPTH (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_chk;
    int n_err;

    logic [31:0] m_pc;
    logic [31:0] m_ras [$];
    logic        m_err;

    task automatic model_step(input logic rst, input logic en,
                              input logic br, input logic [31:0] off,
                              input logic jmp, input logic [31:0] tgt,
                              input logic call, input logic ret);
        logic [31:0] seq;
        logic [31:0] nx;
        logic [31:0] tmp;
        if (rst) begin
            m_pc = 32'h0;
            m_ras.delete();
            m_err = 1'b0;
            return;
        end
        if (!en) return;
        seq = m_pc + 32'd1;
        if (ret) begin
            if (m_ras.size() == 0) begin
                nx = seq;
                m_err = 1'b1;
                if (call) m_ras.push_back(seq);
            end else begin
                nx = m_ras[$];
                if (call) m_ras[$] = seq;
                else tmp = m_ras.pop_back();
            end
        end else begin
            nx = jmp ? tgt : (br ? seq + off : seq);
            if (call) begin
                if (m_ras.size() == 4) begin
                    tmp = m_ras.pop_front();
                    m_err = 1'b1;
                end
                m_ras.push_back(seq);
            end
        end
        m_pc = nx;
    endtask

    task automatic cyc(input logic rst, input logic en,
                       input logic br, input logic [31:0] off,
                       input logic jmp, input logic [31:0] tgt,
                       input logic call, input logic ret);
        RST            = rst;
        bus.EN         = en;
        bus.BR_TAKEN   = br;
        bus.BR_OFFSET  = off;
        bus.JMP        = jmp;
        bus.JMP_TARGET = tgt;
        bus.CALL       = call;
        bus.RET        = ret;
        @(posedge CLK);
        model_step(rst, en, br, off, jmp, tgt, call, ret);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic jump(input logic [31:0] t, input logic call);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, t, call, 1'b0);
    endtask

    task automatic ret_op();
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        n_chk++;
        if (bus.PC !== 32'h0) begin
            $display("FAIL reset_pc got %h exp %h", bus.PC, 32'h0);
            n_err++;
        end
        n_chk++;
        if ({bus.RAS_EMPTY, bus.RAS_FULL, bus.RAS_ERR} !== 3'b100) begin
            $display("FAIL reset_flags got %b exp %b",
                     {bus.RAS_EMPTY, bus.RAS_FULL, bus.RAS_ERR}, 3'b100);
            n_err++;
        end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            idle();
            n_chk++;
            if (bus.PC !== 32'(i)) begin
                $display("FAIL seq_pc got %h exp %h", bus.PC, 32'(i));
                n_err++;
            end
            n_chk++;
            if (bus.PC_NEXT_SEQ !== 32'(i + 1)) begin
                $display("FAIL seq_next got %h exp %h",
                         bus.PC_NEXT_SEQ, 32'(i + 1));
                n_err++;
            end
        end
        n_chk++;
        if ({bus.RAS_EMPTY, bus.RAS_ERR} !== 2'b10) begin
            $display("FAIL seq_flags got %b exp %b",
                     {bus.RAS_EMPTY, bus.RAS_ERR}, 2'b10);
            n_err++;
        end
    endtask

    task automatic test_branch();
        jump(32'h10, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, 32'h0, 1'b0, 1'b0);
        n_chk++;
        if (bus.PC !== 32'h10) begin
            $display("FAIL br_stall got %h exp %h", bus.PC, 32'h10);
            n_err++;
        end
        cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 32'h0, 1'b0, 1'b0);
        n_chk++;
        if (bus.PC !== 32'h0E) begin
            $display("FAIL br_taken got %h exp %h", bus.PC, 32'h0E);
            n_err++;
        end
    endtask

    task automatic test_call_ret();
        jump(32'h20, 1'b0);
        jump(32'h100, 1'b1);
        n_chk++;
        if ({bus.PC, bus.RAS_EMPTY} !== {32'h100, 1'b0}) begin
            $display("FAIL call_pc got %h/%b exp %h/0",
                     bus.PC, bus.RAS_EMPTY, 32'h100);
            n_err++;
        end
        idle();
        idle();
        ret_op();
        n_chk++;
        if ({bus.PC, bus.RAS_EMPTY} !== {32'h21, 1'b1}) begin
            $display("FAIL ret_pc got %h/%b exp %h/1",
                     bus.PC, bus.RAS_EMPTY, 32'h21);
            n_err++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] pushed [5];
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pushed[i] = bus.PC + 32'd1;
            jump(32'h1000 * (i + 1), 1'b1);
        end
        n_chk++;
        if ({bus.RAS_FULL, bus.RAS_ERR} !== 2'b11) begin
            $display("FAIL ovf_flags got %b exp %b",
                     {bus.RAS_FULL, bus.RAS_ERR}, 2'b11);
            n_err++;
        end
        for (int i = 4; i >= 1; i--) begin
            ret_op();
            n_chk++;
            if (bus.PC !== pushed[i]) begin
                $display("FAIL ovf_ret%0d got %h exp %h",
                         i, bus.PC, pushed[i]);
                n_err++;
            end
        end
        exp_pc = bus.PC + 32'd1;
        ret_op();
        n_chk++;
        if ({bus.PC, bus.RAS_EMPTY, bus.RAS_ERR} !== {exp_pc, 2'b11}) begin
            $display("FAIL udf_ret got %h/%b%b exp %h/11",
                     bus.PC, bus.RAS_EMPTY, bus.RAS_ERR, exp_pc);
            n_err++;
        end
    endtask

    task automatic test_priority();
        jump(32'hFFFF_FFFF, 1'b0);
        idle();
        n_chk++;
        if (bus.PC !== 32'h0) begin
            $display("FAIL wrap got %h exp %h", bus.PC, 32'h0);
            n_err++;
        end
        cyc(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h500, 1'b0, 1'b0);
        n_chk++;
        if (bus.PC !== 32'h500) begin
            $display("FAIL jmp_over_br got %h exp %h", bus.PC, 32'h500);
            n_err++;
        end
        jump(32'h700, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h900, 1'b0, 1'b1);
        n_chk++;
        if (bus.PC !== 32'h501) begin
            $display("FAIL ret_over_jmp got %h exp %h", bus.PC, 32'h501);
            n_err++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) jump(32'h40 + 32'(i * 16), 1'b1);
        ret_op();
        ret_op();
        ret_op();
        ret_op();
        for (int i = 0; i < 3; i++) jump(32'h80 + 32'(i * 16), 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0, 1'b0);
        n_chk++;
        if ({bus.PC, bus.RAS_EMPTY, bus.RAS_ERR} !== {32'h0, 2'b10}) begin
            $display("FAIL rst_mid got %h/%b%b exp 0/10",
                     bus.PC, bus.RAS_EMPTY, bus.RAS_ERR);
            n_err++;
        end
    endtask

    task automatic test_random();
        logic rst, en, br, jmp, call, ret;
        logic [31:0] off, tgt;
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(99) < 2);
            en   = ($urandom_range(99) < 85);
            br   = ($urandom_range(99) < 30);
            jmp  = ($urandom_range(99) < 15);
            call = ($urandom_range(99) < 25);
            ret  = ($urandom_range(99) < 25);
            off  = $urandom();
            tgt  = $urandom();
            cyc(rst, en, br, off, jmp, tgt, call, ret);
            n_chk++;
            if (bus.PC !== m_pc) begin
                $display("FAIL rnd_pc@%0d got %h exp %h", i, bus.PC, m_pc);
                n_err++;
            end
            n_chk++;
            if (bus.PC_NEXT_SEQ !== m_pc + 32'd1) begin
                $display("FAIL rnd_next@%0d got %h exp %h",
                         i, bus.PC_NEXT_SEQ, m_pc + 32'd1);
                n_err++;
            end
            n_chk++;
            if ({bus.RAS_EMPTY, bus.RAS_FULL, bus.RAS_ERR} !==
                {m_ras.size() == 0, m_ras.size() == 4, m_err}) begin
                $display("FAIL rnd_flags@%0d got %b exp %b", i,
                         {bus.RAS_EMPTY, bus.RAS_FULL, bus.RAS_ERR},
                         {m_ras.size() == 0, m_ras.size() == 4, m_err});
                n_err++;
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        m_pc  = 32'h0;
        m_err = 1'b0;
        RST            = 1'b1;
        bus.EN         = 1'b0;
        bus.BR_TAKEN   = 1'b0;
        bus.BR_OFFSET  = 32'h0;
        bus.JMP        = 1'b0;
        bus.JMP_TARGET = 32'h0;
        bus.CALL       = 1'b0;
        bus.RET        = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_call_ret();
        test_overflow();
        test_priority();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
